// File: rtl/ram_arbiter_if.sv
// Handshake bundle for one requester of ram_arbiter (CPU or DMA side).
// The requester drives req/we/addr/wdata; the arbiter returns gnt/stall/rvalid/rdata.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              stall;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, stall, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, stall, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM: CPU (cpu) and DMA/debug loader (dma).
// Define ARB_CPU_PRIORITY_EN for fixed CPU priority; default is round-robin with burst limit.
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      cpu,
  ram_arbiter_if.slave      dma,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_read_data
);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_d;
  logic             gnt_c;
  logic             gnt_d;
  logic             xfer_c;
  logic             xfer_d;
  logic             burst_ok;

  assign gnt_c    = (state == OWN_C);
  assign gnt_d    = (state == OWN_D);
  assign xfer_c   = cpu.req & gnt_c;
  assign xfer_d   = dma.req & gnt_d;
  assign burst_ok = (burst_cnt < CNT_LIM);

  assign cpu.gnt   = gnt_c;
  assign dma.gnt   = gnt_d;
  assign cpu.stall = cpu.req & ~gnt_c;
  assign dma.stall = dma.req & ~gnt_d;

  // Grant is a register, so a reset drops ram_write_en without waiting for a clock.
  assign ram_addr       = xfer_c ? cpu.addr : (xfer_d ? dma.addr : '0);
  assign ram_write_data = gnt_c ? cpu.wdata : (gnt_d ? dma.wdata : '0);
  assign ram_write_en   = (xfer_c & cpu.we) | (xfer_d & dma.we);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cpu.req && dma.req) state_nx = last_d ? OWN_C : OWN_D;
        else if (cpu.req)       state_nx = OWN_C;
        else if (dma.req)       state_nx = OWN_D;
      end
      OWN_C: begin
        if (!dma.req) state_nx = cpu.req ? OWN_C : IDLE;
        else          state_nx = (cpu.req && burst_ok) ? OWN_C : OWN_D;
      end
      OWN_D: begin
        if (!cpu.req) state_nx = dma.req ? OWN_D : IDLE;
        else          state_nx = (dma.req && burst_ok) ? OWN_D : OWN_C;
      end
      default: state_nx = IDLE;
    endcase
`ifdef ARB_CPU_PRIORITY_EN
    if (cpu.req) state_nx = OWN_C;
`endif
  end

  // burst_cnt saturates at the limit; a sole requester may keep the RAM indefinitely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_d     <= 1'b1;
      cpu.rvalid <= 1'b0;
      cpu.rdata  <= '0;
      dma.rvalid <= 1'b0;
      dma.rdata  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state_nx == IDLE)
        burst_cnt <= '0;
      else if ((xfer_c || xfer_d) && burst_cnt != CNT_LIM)
        burst_cnt <= burst_cnt + 1'b1;
      if (xfer_c)      last_d <= 1'b0;
      else if (xfer_d) last_d <= 1'b1;
      cpu.rvalid <= xfer_c & ~cpu.we;
      dma.rvalid <= xfer_d & ~dma.we;
      if (xfer_c && !cpu.we) cpu.rdata <= ram_read_data;
      if (xfer_d && !dma.we) dma.rdata <= ram_read_data;
    end
  end
endmodule
